// File: rtl/fme_mvp_cand_fetch_pkg.sv
// Shared types and widths for the spatial MV candidate fetcher.
//   FMV_WIDTH   : width of one MV component (mv_x or mv_y)
//   PIC_X_WIDTH : width of a CTU column index inside the picture
//   fetch_state_e : fetch FSM encodings FETCH_IDLE..FETCH_DONE
//   cand_e        : spatial candidate id (A1, B1, B2)
//   src_e         : MV source a candidate is read from
package fme_mvp_cand_fetch_pkg;

  localparam int FMV_WIDTH   = 12;
  localparam int PIC_X_WIDTH = 8;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_RD_A1 = 3'd1,
    FETCH_RD_B1 = 3'd2,
    FETCH_RD_B2 = 3'd3,
    FETCH_CAP   = 3'd4,
    FETCH_DONE  = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAND_A1 = 2'd0,
    CAND_B1 = 2'd1,
    CAND_B2 = 2'd2
  } cand_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LFT  = 2'd1,
    SRC_TOP  = 2'd2,
    SRC_CUR  = 2'd3
  } src_e;

endpackage

// File: rtl/fme_mvp_nb_addr.sv
// Combinational availability / source / address decoder for one spatial
// neighbour of a PU.
//   cand        : which candidate to decode (A1, B1, B2)
//   ctu_x       : current CTU column
//   first_row   : current CTU lies in picture row 0
//   pu_x..pu_h  : PU origin and size-minus-1, 8x8 units inside the CTU
//   av          : candidate is available
//   src         : buffer to read (SRC_NONE when unavailable)
//   lft_adr     : left buffer row
//   top_adr     : top buffer column, picture-wide 8x8 units
//   cur_adr     : current-CTU store address {row, col}
module fme_mvp_nb_addr
  import fme_mvp_cand_fetch_pkg::*;
#(
  parameter int XW     = PIC_X_WIDTH,
  parameter int TOP_AW = PIC_X_WIDTH + 3
) (
  input  cand_e              cand,
  input  logic [XW-1:0]      ctu_x,
  input  logic               first_row,
  input  logic [2:0]         pu_x,
  input  logic [2:0]         pu_y,
  input  logic [2:0]         pu_w,
  input  logic [2:0]         pu_h,
  output logic               av,
  output src_e               src,
  output logic [2:0]         lft_adr,
  output logic [TOP_AW-1:0]  top_adr,
  output logic [5:0]         cur_adr
);

  logic              a1_ok;
  logic              b1_ok;
  logic [TOP_AW-1:0] base;

  always_comb begin
    a1_ok   = !((pu_x == 3'd0) && (ctu_x == '0));
    b1_ok   = !((pu_y == 3'd0) && first_row);
    base    = TOP_AW'(ctu_x) << 3;
    av      = 1'b0;
    src     = SRC_NONE;
    lft_adr = '0;
    top_adr = '0;
    cur_adr = '0;
    case (cand)
      CAND_A1: begin
        av = a1_ok;
        if (pu_x == 3'd0) begin
          src     = SRC_LFT;
          lft_adr = pu_y + pu_h;
        end else begin
          src     = SRC_CUR;
          cur_adr = {pu_y + pu_h, pu_x - 3'd1};
        end
      end
      CAND_B1: begin
        av = b1_ok;
        if (pu_y == 3'd0) begin
          src     = SRC_TOP;
          top_adr = base + TOP_AW'(pu_x) + TOP_AW'(pu_w);
        end else begin
          src     = SRC_CUR;
          cur_adr = {pu_y - 3'd1, pu_x + pu_w};
        end
      end
      CAND_B2: begin
        av = a1_ok && b1_ok;
        if (pu_y == 3'd0) begin
          // pu_x==0 lands on the previous CTU's last column, where the top
          // buffer holds the saved top-left MV.
          src     = SRC_TOP;
          top_adr = base + TOP_AW'(pu_x) - TOP_AW'(1);
        end else if (pu_x == 3'd0) begin
          src     = SRC_LFT;
          lft_adr = pu_y - 3'd1;
        end else begin
          src     = SRC_CUR;
          cur_adr = {pu_y - 3'd1, pu_x - 3'd1};
        end
      end
      default: ;
    endcase
    if (!av) src = SRC_NONE;
  end

endmodule

// File: rtl/fme_mvp_cand_fetch.sv
// Spatial MV candidate fetcher. For each PU request it reads the A1, B1 and
// B2 neighbours from the left MV buffer, the top MV buffer or the current-CTU
// MV store, and returns candidates, availability and duplicate flags.
//   clk, rst                 : clock, synchronous active-high reset
//   start_i                  : PU request pulse (ignored while busy)
//   ctu_x_i, ctu_first_row_i : CTU position
//   pu_x_i..pu_h_i           : PU geometry in 8x8 units
//   lft_rd_* / top_rd_* / cur_rd_* : buffer read ports, 1-cycle read latency
//   busy_o, done_o           : request in flight / results valid pulse
//   a1_o, b1_o, b2_o         : candidate MVs (0 when unavailable)
//   *_av_o, *_dup_o          : availability and duplicate flags
module fme_mvp_cand_fetch
  import fme_mvp_cand_fetch_pkg::*;
#(
  parameter int MV_W   = 2 * FMV_WIDTH,
  parameter int TOP_AW = PIC_X_WIDTH + 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [PIC_X_WIDTH-1:0] ctu_x_i,
  input  logic                   ctu_first_row_i,
  input  logic [2:0]             pu_x_i,
  input  logic [2:0]             pu_y_i,
  input  logic [2:0]             pu_w_i,
  input  logic [2:0]             pu_h_i,
  output logic                   lft_rd_ena_o,
  output logic [2:0]             lft_rd_adr_o,
  input  logic [MV_W-1:0]        lft_rd_dat_i,
  output logic                   top_rd_ena_o,
  output logic [TOP_AW-1:0]      top_rd_adr_o,
  input  logic [MV_W-1:0]        top_rd_dat_i,
  output logic                   cur_rd_ena_o,
  output logic [5:0]             cur_rd_adr_o,
  input  logic [MV_W-1:0]        cur_rd_dat_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [MV_W-1:0]        a1_o,
  output logic [MV_W-1:0]        b1_o,
  output logic [MV_W-1:0]        b2_o,
  output logic                   a1_av_o,
  output logic                   b1_av_o,
  output logic                   b2_av_o,
  output logic                   b1_dup_o,
  output logic                   b2_dup_o
);

  function automatic logic mv_dup(input logic av_a, input logic av_b,
                                  input logic [MV_W-1:0] mv_a,
                                  input logic [MV_W-1:0] mv_b);
    return av_a && av_b && (mv_a == mv_b);
  endfunction

  fetch_state_e           state_q, state_d;
  logic                   accept;
  logic                   rd_state;
  cand_e                  nb_cand;

  logic [PIC_X_WIDTH-1:0] ctu_x_q;
  logic                   first_row_q;
  logic [2:0]             pu_x_q, pu_y_q, pu_w_q, pu_h_q;

  logic                   nb_av;
  src_e                   nb_src;
  logic [2:0]             nb_lft_adr;
  logic [TOP_AW-1:0]      nb_top_adr;
  logic [5:0]             nb_cur_adr;

  src_e                   pend_src_p1;
  logic [MV_W-1:0]        rd_mv_p1;

  assign accept = (state_q == FETCH_IDLE) && start_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rd_state = 1'b0;
    nb_cand  = CAND_A1;
    case (state_q)
      FETCH_IDLE:  if (start_i) state_d = FETCH_RD_A1;
      FETCH_RD_A1: begin state_d = FETCH_RD_B1; rd_state = 1'b1; nb_cand = CAND_A1; end
      FETCH_RD_B1: begin state_d = FETCH_RD_B2; rd_state = 1'b1; nb_cand = CAND_B1; end
      FETCH_RD_B2: begin state_d = FETCH_CAP;   rd_state = 1'b1; nb_cand = CAND_B2; end
      FETCH_CAP:   state_d = FETCH_DONE;
      FETCH_DONE:  state_d = FETCH_IDLE;
      default:     state_d = FETCH_IDLE;
    endcase
  end

  assign busy_o = (state_q != FETCH_IDLE);
  assign done_o = (state_q == FETCH_DONE);

  // Request geometry is held for the whole fetch.
  always_ff @(posedge clk) begin
    if (accept) begin
      ctu_x_q     <= ctu_x_i;
      first_row_q <= ctu_first_row_i;
      pu_x_q      <= pu_x_i;
      pu_y_q      <= pu_y_i;
      pu_w_q      <= pu_w_i;
      pu_h_q      <= pu_h_i;
    end
  end

  fme_mvp_nb_addr #(
    .XW     (PIC_X_WIDTH),
    .TOP_AW (TOP_AW)
  ) u_nb_addr (
    .cand      (nb_cand),
    .ctu_x     (ctu_x_q),
    .first_row (first_row_q),
    .pu_x      (pu_x_q),
    .pu_y      (pu_y_q),
    .pu_w      (pu_w_q),
    .pu_h      (pu_h_q),
    .av        (nb_av),
    .src       (nb_src),
    .lft_adr   (nb_lft_adr),
    .top_adr   (nb_top_adr),
    .cur_adr   (nb_cur_adr)
  );

  // ---- issue stage (p0): one read per RD state ----
  always_comb begin
    lft_rd_ena_o = rd_state && (nb_src == SRC_LFT);
    top_rd_ena_o = rd_state && (nb_src == SRC_TOP);
    cur_rd_ena_o = rd_state && (nb_src == SRC_CUR);
    lft_rd_adr_o = lft_rd_ena_o ? nb_lft_adr : '0;
    top_rd_adr_o = top_rd_ena_o ? nb_top_adr : '0;
    cur_rd_adr_o = cur_rd_ena_o ? nb_cur_adr : '0;
  end

  // ---- return stage (p1): only the port read last cycle is looked at ----
  always_comb begin
    case (pend_src_p1)
      SRC_LFT: rd_mv_p1 = lft_rd_dat_i;
      SRC_TOP: rd_mv_p1 = top_rd_dat_i;
      SRC_CUR: rd_mv_p1 = cur_rd_dat_i;
      default: rd_mv_p1 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_src_p1 <= SRC_NONE;
      a1_o        <= '0;
      b1_o        <= '0;
      b2_o        <= '0;
      a1_av_o     <= 1'b0;
      b1_av_o     <= 1'b0;
      b2_av_o     <= 1'b0;
      b1_dup_o    <= 1'b0;
      b2_dup_o    <= 1'b0;
    end else begin
      pend_src_p1 <= rd_state ? nb_src : SRC_NONE;
      if (accept) begin
        b1_dup_o <= 1'b0;
        b2_dup_o <= 1'b0;
      end
      case (state_q)
        FETCH_RD_A1: a1_av_o <= nb_av;
        FETCH_RD_B1: begin
          b1_av_o <= nb_av;
          a1_o    <= rd_mv_p1;
        end
        FETCH_RD_B2: begin
          b2_av_o <= nb_av;
          b1_o    <= rd_mv_p1;
        end
        FETCH_CAP: begin
          b2_o     <= rd_mv_p1;
          b1_dup_o <= mv_dup(b1_av_o, a1_av_o, b1_o, a1_o);
          b2_dup_o <= mv_dup(b2_av_o, b1_av_o, rd_mv_p1, b1_o);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fme_mvp_cand_fetch.sv
module tb_fme_mvp_cand_fetch;

  localparam int MV_W   = 24;
  localparam int TOP_AW = 11;
  localparam logic [23:0] GARB = 24'hABCDEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        ctu_x;
  logic              first_row;
  logic [2:0]        pu_x, pu_y, pu_w, pu_h;
  logic              lft_ena, top_ena, cur_ena;
  logic [2:0]        lft_adr;
  logic [TOP_AW-1:0] top_adr;
  logic [5:0]        cur_adr;
  logic [MV_W-1:0]   lft_dat, top_dat, cur_dat;
  logic              busy, done;
  logic [MV_W-1:0]   a1, b1, b2;
  logic              a1_av, b1_av, b2_av, b1_dup, b2_dup;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fme_mvp_cand_fetch #(.MV_W(MV_W), .TOP_AW(TOP_AW)) dut (
    .clk(clk), .rst(rst), .start_i(start),
    .ctu_x_i(ctu_x), .ctu_first_row_i(first_row),
    .pu_x_i(pu_x), .pu_y_i(pu_y), .pu_w_i(pu_w), .pu_h_i(pu_h),
    .lft_rd_ena_o(lft_ena), .lft_rd_adr_o(lft_adr), .lft_rd_dat_i(lft_dat),
    .top_rd_ena_o(top_ena), .top_rd_adr_o(top_adr), .top_rd_dat_i(top_dat),
    .cur_rd_ena_o(cur_ena), .cur_rd_adr_o(cur_adr), .cur_rd_dat_i(cur_dat),
    .busy_o(busy), .done_o(done),
    .a1_o(a1), .b1_o(b1), .b2_o(b2),
    .a1_av_o(a1_av), .b1_av_o(b1_av), .b2_av_o(b2_av),
    .b1_dup_o(b1_dup), .b2_dup_o(b2_dup)
  );

  // rd[k]: expected read in RD slot k as {src nibble, 12-bit address}
  // (1=lft, 2=top, 3=cur, 0=no read). resp[k]: data returned for slot k.
  typedef struct {
    logic [7:0]  ctu_x;
    logic        first_row;
    logic [2:0]  px, py, pw, ph;
    logic [15:0] rd [3];
    logic [23:0] resp [3];
    logic [23:0] a1, b1, b2;
    logic [2:0]  av;   // {a1, b1, b2}
    logic [1:0]  dup;  // {b1_dup, b2_dup}
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] observed_read();
    int n = 0;
    logic [15:0] r = 16'h0000;
    if (lft_ena) begin n++; r = 16'h1000 | 16'(lft_adr); end
    if (top_ena) begin n++; r = 16'h2000 | 16'(top_adr); end
    if (cur_ena) begin n++; r = 16'h3000 | 16'(cur_adr); end
    if (n > 1) r = 16'hFFFF;
    return r;
  endfunction

  task automatic set_vec(input vec_t v);
    ctu_x = v.ctu_x; first_row = v.first_row;
    pu_x = v.px; pu_y = v.py; pu_w = v.pw; pu_h = v.ph;
  endtask

  // mode 0: plain; 1: extra start during busy; 2: extra start in DONE cycle
  task automatic run_vec(input int vi, input int mode);
    vec_t v;
    logic [15:0] obs;
    logic [15:0] pend;
    int pend_slot;
    v = vecs[vi];
    set_vec(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    pend = 16'h0000;
    pend_slot = 0;
    for (int k = 1; k <= 6; k++) begin
      if (mode == 1 && k == 2) start = 1'b1;
      if (mode == 1 && k == 3) start = 1'b0;
      if (mode == 2 && k == 5) start = 1'b1;
      if (mode == 2 && k == 6) start = 1'b0;
      lft_dat = GARB; top_dat = GARB; cur_dat = GARB;
      if (pend_slot <= 2) begin
        case (pend[15:12])
          4'h1: lft_dat = v.resp[pend_slot];
          4'h2: top_dat = v.resp[pend_slot];
          4'h3: cur_dat = v.resp[pend_slot];
          default: ;
        endcase
      end
      obs = observed_read();
      chk($sformatf("v%0d read k%0d", vi, k), 64'(obs), (k <= 3) ? 64'(v.rd[k-1]) : 64'h0);
      pend = obs;
      pend_slot = k - 1;
      chk($sformatf("v%0d busy k%0d", vi, k), 64'(busy), (k <= 5) ? 64'h1 : 64'h0);
      chk($sformatf("v%0d done k%0d", vi, k), 64'(done), (k == 5) ? 64'h1 : 64'h0);
      if (k == 5) begin
        chk($sformatf("v%0d a1", vi), 64'(a1), 64'(v.a1));
        chk($sformatf("v%0d b1", vi), 64'(b1), 64'(v.b1));
        chk($sformatf("v%0d b2", vi), 64'(b2), 64'(v.b2));
        chk($sformatf("v%0d av", vi), 64'({a1_av, b1_av, b2_av}), 64'(v.av));
        chk($sformatf("v%0d dup", vi), 64'({b1_dup, b2_dup}), 64'(v.dup));
      end
      if (k < 6) tick();
    end
    if (mode != 0) begin
      tick();
      chk($sformatf("v%0d dropped start busy", vi), 64'(busy), 64'h0);
      chk($sformatf("v%0d held a1", vi), 64'(a1), 64'(v.a1));
    end
  endtask

  function automatic vec_t mk(input logic [7:0] cx, input logic fr,
                              input logic [2:0] px, input logic [2:0] py,
                              input logic [2:0] pw, input logic [2:0] ph,
                              input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                              input logic [23:0] d0, input logic [23:0] d1, input logic [23:0] d2,
                              input logic [23:0] ea1, input logic [23:0] eb1, input logic [23:0] eb2,
                              input logic [2:0] av, input logic [1:0] dup);
    vec_t v;
    v.ctu_x = cx; v.first_row = fr; v.px = px; v.py = py; v.pw = pw; v.ph = ph;
    v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2;
    v.resp[0] = d0; v.resp[1] = d1; v.resp[2] = d2;
    v.a1 = ea1; v.b1 = eb1; v.b2 = eb2; v.av = av; v.dup = dup;
    return v;
  endfunction

  initial begin
    // interior PU: A1 {3,1}, B1 {1,3}, B2 {1,1}
    vecs[0] = mk(8'd3, 1'b0, 3'd2, 3'd2, 3'd1, 3'd1, 16'h3019, 16'h300B, 16'h3009,
                 24'h111111, 24'h222222, 24'h333333, 24'h111111, 24'h222222, 24'h333333, 3'b111, 2'b00);
    // left-edge PU
    vecs[1] = mk(8'd2, 1'b0, 3'd0, 3'd4, 3'd0, 3'd1, 16'h1005, 16'h3018, 16'h1003,
                 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 3'b111, 2'b00);
    // top-edge PU: B1 col 43, B2 col 39 (previous CTU)
    vecs[2] = mk(8'd5, 1'b0, 3'd0, 3'd0, 3'd3, 3'd0, 16'h1000, 16'h202B, 16'h2027,
                 24'h000AAA, 24'h000BBB, 24'h000CCC, 24'h000AAA, 24'h000BBB, 24'h000CCC, 3'b111, 2'b00);
    // picture corner: nothing available
    vecs[3] = mk(8'd0, 1'b1, 3'd0, 3'd0, 3'd7, 3'd7, 16'h0000, 16'h0000, 16'h0000,
                 24'h777777, 24'h777777, 24'h777777, 24'h0, 24'h0, 24'h0, 3'b000, 2'b00);
    // all three equal
    vecs[4] = mk(8'd3, 1'b0, 3'd2, 3'd2, 3'd1, 3'd1, 16'h3019, 16'h300B, 16'h3009,
                 24'h012345, 24'h012345, 24'h012345, 24'h012345, 24'h012345, 24'h012345, 3'b111, 2'b11);
    // B2 differs
    vecs[5] = mk(8'd3, 1'b0, 3'd2, 3'd2, 3'd1, 3'd1, 16'h3019, 16'h300B, 16'h3009,
                 24'h012345, 24'h012345, 24'h000001, 24'h012345, 24'h012345, 24'h000001, 3'b111, 2'b10);
    // top picture row, interior column: only A1
    vecs[6] = mk(8'd0, 1'b1, 3'd3, 3'd0, 3'd1, 3'd2, 16'h3012, 16'h0000, 16'h0000,
                 24'h055555, 24'h0, 24'h0, 24'h055555, 24'h0, 24'h0, 3'b100, 2'b00);
    // left picture edge: only B1, zero MV must not count as dup with absent A1
    vecs[7] = mk(8'd0, 1'b1, 3'd0, 3'd3, 3'd1, 3'd0, 16'h0000, 16'h3011, 16'h0000,
                 24'h0, 24'h000000, 24'h0, 24'h0, 24'h000000, 24'h0, 3'b010, 2'b00);

    rst = 1'b1; start = 1'b0;
    lft_dat = GARB; top_dat = GARB; cur_dat = GARB;
    set_vec(vecs[0]);
    repeat (3) tick();
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    chk("reset enables", 64'({lft_ena, top_ena, cur_ena}), 64'h0);
    chk("reset outputs", 64'({a1, b1, b2, a1_av, b1_av, b2_av, b1_dup, b2_dup} != '0), 64'h0);
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(i, 0);
      tick();
    end

    // corner: start while busy, then start in the DONE cycle
    run_vec(0, 1);
    tick();
    run_vec(1, 2);
    tick();

    // reset in the middle of a request
    begin
      int saw_done = 0;
      set_vec(vecs[0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();          // T+2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst busy", 64'(busy), 64'h0);
      chk("midrst enables", 64'({lft_ena, top_ena, cur_ena}), 64'h0);
      chk("midrst a1", 64'(a1), 64'h0);
      for (int k = 0; k < 6; k++) begin
        if (done || busy) saw_done++;
        tick();
      end
      chk("midrst no done", 64'(saw_done), 64'h0);
    end

    // recovery after reset
    run_vec(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
